// File: rtl/tt_um_hoene_manchester_encoder.sv
// Manchester transmitter (IEEE 802.3 polarity: '1' = low->high, '0' = high->low).
// Accepts parallel words over a valid/ready handshake and sends each frame as
// preamble ('1' bits), one '0' start bit, the data words MSB first, and then an
// idle gap of zeros so a downstream decoder can re-lock before the next frame.
//
// Handshake: a word transfers on a rising clk edge where in_valid and in_ready
// are both high. in_ready is a registered output and never depends on in_valid,
// in_valid may drop without a transfer, and in_data/in_last are sampled only on
// the transfer edge.
//
// Every output is registered. The position registers (state, hb_cnt, phase,
// bit_cnt) always describe the half-bit that is on the line in the current
// cycle, and each edge advances them together with the outputs.
module tt_um_hoene_manchester_encoder #(
  parameter int HALF_BIT_CYCLES = 4,
  parameter int WORD_BITS       = 32,
  parameter int PREAMBLE_BITS   = 8,
  parameter int GAP_BITS        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out,
  output logic                 out_active,
  output logic                 out_bit_strb,
  output logic                 out_underrun
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_START    = 3'd2,
    S_DATA     = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  localparam int CW         = $clog2(HALF_BIT_CYCLES);
  localparam int BIT_MAX    = (WORD_BITS > PREAMBLE_BITS) ? WORD_BITS : PREAMBLE_BITS;
  localparam int BW         = $clog2(BIT_MAX) + 1;
  localparam int GAP_CYCLES = GAP_BITS * 2 * HALF_BIT_CYCLES;
  localparam int GW         = $clog2(GAP_CYCLES) + 1;

  localparam logic [CW-1:0] HB_LAST  = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [CW-1:0] HB_PEN   = CW'(HALF_BIT_CYCLES - 2);
  localparam logic [BW-1:0] P_LAST   = BW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] W_LAST   = BW'(WORD_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  // state is kept as a named enum so checkers can bind to it hierarchically
  state_t               state;
  logic [CW-1:0]        hb_cnt;
  logic                 phase;
  logic [BW-1:0]        bit_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [WORD_BITS-1:0] shreg;
  logic                 last_q;

  logic                 half_end;
  logic                 cur_bit;
  logic [WORD_BITS-1:0] sh_next;
  logic                 pre_final;
  logic                 accept;

  // Decode the current line position: half-bit wrap, bit value being sent,
  // and whether the next cycle is the final cycle of a non-last word.
  always_comb begin
    half_end  = (hb_cnt == HB_LAST);
    sh_next   = shreg << 1;
    accept    = in_valid & in_ready;
    cur_bit   = 1'b0;
    case (state)
      S_PREAMBLE: cur_bit = 1'b1;
      S_START:    cur_bit = 1'b0;
      S_DATA:     cur_bit = shreg[WORD_BITS-1];
      default:    cur_bit = 1'b0;
    endcase
    pre_final = (state == S_DATA) & phase & (hb_cnt == HB_PEN) &
                (bit_cnt == W_LAST) & ~last_q;
  end

  // Framing FSM: advances the line position and drives all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      hb_cnt       <= '0;
      phase        <= 1'b0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      shreg        <= '0;
      last_q       <= 1'b0;
      out          <= 1'b0;
      out_active   <= 1'b0;
      out_bit_strb <= 1'b0;
      out_underrun <= 1'b0;
      in_ready     <= 1'b0;
    end else begin
      out_bit_strb <= 1'b0;
      out_underrun <= 1'b0;
      in_ready     <= 1'b0;
      case (state)
        S_IDLE: begin
          out        <= 1'b0;
          out_active <= 1'b0;
          if (accept) begin
            shreg        <= in_data;
            last_q       <= in_last;
            state        <= S_PREAMBLE;
            hb_cnt       <= '0;
            phase        <= 1'b0;
            bit_cnt      <= '0;
            out          <= 1'b0;   // first half of a preamble '1'
            out_active   <= 1'b1;
            out_bit_strb <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_GAP: begin
          out        <= 1'b0;
          out_active <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          in_ready <= pre_final;
          if (!half_end) begin
            hb_cnt <= hb_cnt + 1'b1;
          end else begin
            hb_cnt <= '0;
            if (!phase) begin
              phase <= 1'b1;
              out   <= cur_bit;          // second half carries the bit value
            end else begin
              phase <= 1'b0;
              case (state)
                S_PREAMBLE: begin
                  out_bit_strb <= 1'b1;
                  if (bit_cnt == P_LAST) begin
                    state <= S_START;
                    out   <= 1'b1;       // start bit '0' opens high
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    out     <= 1'b0;
                  end
                end
                S_START: begin
                  state        <= S_DATA;
                  bit_cnt      <= '0;
                  out          <= ~shreg[WORD_BITS-1];
                  out_bit_strb <= 1'b1;
                end
                S_DATA: begin
                  if (bit_cnt != W_LAST) begin
                    shreg        <= sh_next;
                    bit_cnt      <= bit_cnt + 1'b1;
                    out          <= ~sh_next[WORD_BITS-1];
                    out_bit_strb <= 1'b1;
                  end else if (accept) begin
                    // chained word: continue straight into its MSB
                    shreg        <= in_data;
                    last_q       <= in_last;
                    bit_cnt      <= '0;
                    out          <= ~in_data[WORD_BITS-1];
                    out_bit_strb <= 1'b1;
                  end else begin
                    state        <= S_GAP;
                    gap_cnt      <= '0;
                    bit_cnt      <= '0;
                    out          <= 1'b0;
                    out_active   <= 1'b0;
                    out_underrun <= ~last_q;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// Bench for the Manchester encoder: reset checks, a table of single frames with
// hand-derived line waveforms, hand sequences for chaining, underrun and reset
// mid-frame, an in-bench line decoder, and randomized frames against a
// bit-level reference model.
module tb_tt_um_hoene_manchester_encoder;

  localparam int H = 2;
  localparam int W = 8;
  localparam int P = 4;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic         out;
  logic         out_active;
  logic         out_bit_strb;
  logic         out_underrun;

  int total = 0;
  int bad   = 0;

  // per-cycle expectation packed as {in_ready, out_underrun, out_bit_strb, out_active, out}
  logic [4:0] exp_q[$];
  logic [W-1:0] frame_w[4];
  logic line_s[0:255];
  int   line_n;

  typedef struct {
    logic [W-1:0] data;
    logic [31:0]  exp_wave;   // data-section line, first cycle in bit 31
  } vec_t;
  vec_t vecs[4];

  tt_um_hoene_manchester_encoder #(
    .HALF_BIT_CYCLES(H), .WORD_BITS(W), .PREAMBLE_BITS(P), .GAP_BITS(G)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_active(out_active), .out_bit_strb(out_bit_strb),
    .out_underrun(out_underrun)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: one line bit = 2H cycles, ~b then b
  task automatic push_bit(input logic b, input logic rdy_end);
    for (int c = 0; c < 2*H; c++)
      exp_q.push_back({rdy_end && (c == 2*H-1), 1'b0, c == 0, 1'b1, (c < H) ? ~b : b});
  endtask

  task automatic build_model(input int n, input logic drop);
    logic lst;
    exp_q.delete();
    for (int i = 0; i < P; i++) push_bit(1'b1, 1'b0);
    push_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      lst = (i == n-1) && !drop;
      for (int b = W-1; b >= 0; b--) push_bit(frame_w[i][b], (b == 0) && !lst);
    end
    for (int c = 0; c < 2*H*G; c++)
      exp_q.push_back({1'b0, drop && (c == 0), 1'b0, 1'b0, 1'b0});
  endtask

  // send frame_w[0..n-1]; with drop the final word carries last=0 and valid then falls
  task automatic run_frame(input int n, input logic drop);
    int idx, guard, rdy_cnt, ur_cnt;
    logic acc;
    logic [4:0] e;
    build_model(n, drop);
    @(negedge clk);
    in_data  = frame_w[0];
    in_last  = (n == 1) && !drop;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    idx = 0; acc = 1'b1; line_n = 0; rdy_cnt = 0; ur_cnt = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < n) begin
          in_data  = frame_w[idx];
          in_last  = (idx == n-1) && !drop;
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
          in_data  = W'($urandom);
        end
      end
      e = exp_q.pop_front();
      chk("cycle", 32'({in_ready, out_underrun, out_bit_strb, out_active, out}), 32'(e));
      line_s[line_n] = out;
      line_n++;
      rdy_cnt += int'(in_ready);
      ur_cnt  += int'(out_underrun);
      acc = in_valid && in_ready;
    end
    chk("accepted_words", 32'(idx), 32'(n));
    chk("ready_pulses", 32'(rdy_cnt), 32'(n - 1 + int'(drop)));
    chk("underrun_pulses", 32'(ur_cnt), 32'(int'(drop)));
    @(negedge clk);
    chk("idle_ready", 32'({in_ready, out_active, out}), 32'b100);
  endtask

  initial begin
    logic [31:0] wave;
    logic [19:0] head;
    logic [W-1:0] dec;
    logic err;
    int strb_n, strb_first, strb_prev, strb_gap_bad;

    vecs[0] = '{8'hA5, 32'h3C3CC3C3};
    vecs[1] = '{8'hFF, 32'h33333333};
    vecs[2] = '{8'h00, 32'hCCCCCCCC};
    vecs[3] = '{8'h81, 32'h3CCCCCC3};

    // reset
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", 32'({in_ready, out_underrun, out_bit_strb, out_active, out}), 32'd0);
    end
    rst = 1'b0;

    // table of single frames with hand-derived waveforms
    for (int v = 0; v < 4; v++) begin
      frame_w[0] = vecs[v].data;
      run_frame(1, 1'b0);
      for (int j = 0; j < 20; j++) head[19-j] = line_s[j];
      for (int j = 0; j < 32; j++) wave[31-j] = line_s[20+j];
      chk("preamble_start", 32'(head), 32'h3333C);
      chk("data_wave", wave, vecs[v].exp_wave);
    end

    // decode the A5 line back: mid-bit transition in every bit, value from second half
    frame_w[0] = 8'hA5;
    run_frame(1, 1'b0);
    err = 1'b0; dec = '0;
    for (int i = 0; i < P + 1 + W; i++) begin
      if (line_s[2*H*i] == line_s[2*H*i+H]) err = 1'b1;
      if (i > P) dec = {dec[W-2:0], line_s[2*H*i+H]};
    end
    chk("decode_err", 32'(err), 32'd0);
    chk("decode_start", 32'(line_s[2*H*P+H]), 32'd0);
    chk("decode_word", 32'(dec), 32'hA5);

    // back-to-back chaining and underrun
    frame_w[0] = 8'hFF; frame_w[1] = 8'h00;
    run_frame(2, 1'b0);
    frame_w[0] = 8'h81;
    run_frame(1, 1'b1);

    // strobe spacing over a fresh A5 frame, then reset during DATA at cycle 30
    @(negedge clk);
    in_data = 8'hA5; in_last = 1'b1; in_valid = 1'b1;
    for (int g = 0; g < 100 && !in_ready; g++) @(negedge clk);
    chk("rst_test_ready", 32'(in_ready), 32'd1);
    strb_n = 0; strb_first = -1; strb_prev = 0; strb_gap_bad = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (out_bit_strb) begin
        if (strb_first < 0) strb_first = c;
        else if (c - strb_prev != 2*H) strb_gap_bad++;
        strb_prev = c;
        strb_n++;
      end
    end
    chk("strb_first", 32'(strb_first), 32'd1);
    chk("strb_spacing", 32'(strb_gap_bad), 32'd0);
    chk("strb_count_c30", 32'(strb_n), 32'd8);
    chk("active_c30", 32'(out_active), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", 32'({in_ready, out_underrun, out_bit_strb, out_active, out}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // randomized frames against the model
    for (int r = 0; r < 10; r++) begin
      int n;
      logic drop;
      n = $urandom_range(1, 3);
      drop = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) frame_w[i] = W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(n, drop);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
